hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Decides when the IF and ID stages freeze.
- Drives flushE, which connects directly to the clr input of the ID/EX pipeline register; while it is high, a bubble is inserted into EX.
- Owns the busy tracking for the multi-cycle mult/div unit and a saturating stall-cycle counter for performance debug.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/md_tracker.sv | 47 ++++
 rtl/hazard_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: mult/div latencies, register-zero constant and
// the mult/div kind encoding.
package mips_pkg;

   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      MD_MULT = 1'b0,
      MD_DIV  = 1'b1
   } md_kind_e;

   typedef enum logic {
      MdIdle = 1'b0,
      MdBusy = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_tracker.sv
// Busy tracking for the multi-cycle mult/div unit: a down-counter loaded with the
// operation latency on an accepted start.
module md_tracker
   import mips_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   input  logic kind_i,
   output logic busy_o
);

   localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CW     = $clog2(MaxLat + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   md_state_e     state;

   // The state is the counter itself: non-zero means the unit is occupied.
   assign state = (cnt_q != '0) ? MdBusy : MdIdle;

   always_comb begin
      cnt_d = cnt_q;
      unique case (state)
         MdIdle: begin
            if (start_i) begin
               cnt_d = (md_kind_e'(kind_i) == MD_DIV) ? CW'(DIV_LAT) : CW'(MULT_LAT);
            end
         end
         MdBusy: cnt_d = cnt_q - CW'(1);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (state == MdBusy);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes IF/ID and bubbles EX on load-use, branch-compare
// and HI/LO hazards; also counts stalled cycles for performance debug.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rsD,
   input  logic [4:0]       rtD,
   input  logic             rs_useD,
   input  logic             rt_useD,
   input  logic             br_useD,
   input  logic             md_startD,
   input  logic             md_kindD,
   input  logic             md_useD,
   input  logic             regwriteE,
   input  logic             memreadE,
   input  logic [4:0]       writeregE,
   input  logic             regwriteM,
   input  logic             memtoregM,
   input  logic [4:0]       writeregM,
   output logic             stallF,
   output logic             stallD,
   output logic             flushE,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   logic e_valid, m_valid;
   logic lw_stall, br_stall, md_stall, stall;
   logic br_hit_e, br_hit_m;
   logic busy;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic unused_regwrite_m;

   // Loads are already covered by memtoregM; a plain MEM-stage write is forwarded.
   assign unused_regwrite_m = regwriteM;

   assign e_valid = (writeregE != REG_ZERO);
   assign m_valid = (writeregM != REG_ZERO);

   assign lw_stall = memreadE & e_valid &
                     ((rs_useD & (rsD == writeregE)) | (rt_useD & (rtD == writeregE)));

   assign br_hit_e = regwriteE & e_valid & ((rsD == writeregE) | (rtD == writeregE));
   assign br_hit_m = memtoregM & m_valid & ((rsD == writeregM) | (rtD == writeregM));
   assign br_stall = br_useD & (br_hit_e | br_hit_m);

   assign md_stall = md_useD & busy;

   // Outputs are held low while reset is asserted, whatever the inputs are doing.
   assign stall = rst_n & (lw_stall | br_stall | md_stall);

   md_tracker #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_tracker (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (md_startD & ~stall),
      .kind_i  (md_kindD),
      .busy_o  (busy)
   );

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stallF    = stall;
   assign stallD    = stall;
   assign flushE    = stall;
   assign md_busy   = busy;
   assign stall_cnt = stall_cnt_q;

endmodule
